// File: rtl/product_accumulator_if.sv
// Handshake bundle between the multiplier-side producer, the accumulator and the result consumer.
// Both channels use valid/ready: a transfer happens on a rising clk edge where valid and ready are both 1.
interface product_accumulator_if #(
    parameter int PW    = 8,
    parameter int AW    = 12,
    parameter int TERMS = 4
);
    localparam int CW = $clog2(TERMS + 1);

    logic          in_valid;
    logic          in_ready;
    logic [PW-1:0] product;
    logic          sub;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_sum;
    logic [CW-1:0] out_terms;
    logic          out_overflow;

    modport master (
        output in_valid, product, sub, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_terms, out_overflow
    );

    modport slave (
        input  in_valid, product, sub, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_terms, out_overflow
    );
endinterface

// File: rtl/product_accumulator.sv
// Signed multiply-accumulate back end: sums TERMS unsigned products (add or subtract) and holds the result.
// Define PACC_SATURATE_EN to clamp on signed overflow instead of wrapping modulo 2^AW.
module product_accumulator #(
    parameter int PW    = 8,
    parameter int AW    = 12,
    parameter int TERMS = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    product_accumulator_if.slave bus,
    output logic                 state_dbg
);
    localparam int CW = $clog2(TERMS + 1);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] acc_q;
    logic [CW-1:0] count_q;
    logic          ovf_q;
    logic [AW-1:0] out_sum_q;
    logic [CW-1:0] out_terms_q;
    logic          out_ovf_q;

    logic          accept;
    logic          done;
    logic          release_hold;
    logic [AW:0]   sum_ext;
    logic          step_ovf;
    logic [AW-1:0] acc_next;

    // One extra bit holds the exact result; the top two bits disagreeing means the AW-bit result overflowed.
    always_comb begin
        sum_ext  = bus.sub ? ({acc_q[AW-1], acc_q} - (AW+1)'(bus.product))
                           : ({acc_q[AW-1], acc_q} + (AW+1)'(bus.product));
        step_ovf = sum_ext[AW] ^ sum_ext[AW-1];
`ifdef PACC_SATURATE_EN
        if (step_ovf)
            acc_next = sum_ext[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
        else
            acc_next = sum_ext[AW-1:0];
`else
        acc_next = sum_ext[AW-1:0];
`endif
    end

    always_comb begin
        state_d       = state_q;
        accept        = 1'b0;
        done          = 1'b0;
        release_hold  = 1'b0;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state_q)
            ACCUM: begin
                bus.in_ready = 1'b1;
                accept       = bus.in_valid;
                if (accept && (bus.in_last || count_q == CW'(TERMS - 1))) begin
                    done    = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    release_hold = 1'b1;
                    state_d      = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ACCUM;
            acc_q       <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            out_sum_q   <= '0;
            out_terms_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                acc_q   <= acc_next;
                count_q <= count_q + CW'(1);
                ovf_q   <= ovf_q | step_ovf;
            end
            if (done) begin
                out_sum_q   <= acc_next;
                out_terms_q <= count_q + CW'(1);
                out_ovf_q   <= ovf_q | step_ovf;
            end
            // The group is cleared only once the consumer has taken the result.
            if (release_hold) begin
                acc_q   <= '0;
                count_q <= '0;
                ovf_q   <= 1'b0;
            end
        end
    end

    assign bus.out_sum      = out_sum_q;
    assign bus.out_terms    = out_terms_q;
    assign bus.out_overflow = out_ovf_q;
    assign state_dbg        = (state_q == HOLD);
endmodule
